// File: rtl/gba_cart_bus.sv
// GBA cartridge bus engine: strobe synchronisers, address latch/increment,
// ROM / mapped-register read path and register write decode.
module gba_cart_bus #(
    parameter int          ROM_AW      = 10,
    parameter logic [15:0] REG_BASE    = 16'h0400,
    parameter int          NUM_REGS    = 4,
    parameter int          SYNC_STAGES = 3,
    parameter logic [15:0] REG_RESET   = 16'h0000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CS,
    input  logic                    RD,
    input  logic                    WR,
    input  logic [15:0]             A_IN,
    output logic [15:0]             D_OUT,
    output logic                    D_OE,
    output logic [ROM_AW-1:0]       ROM_ADDR,
    input  logic [15:0]             ROM_DATA,
    output logic [16*NUM_REGS-1:0]  REGS,
    output logic [NUM_REGS-1:0]     REG_WSTB,
    output logic                    BUSY
);

    localparam int S  = SYNC_STAGES;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FETCH} state_t;

    state_t          state, state_n;
    logic [S-1:0]    cs_h, rd_h, wr_h;
    logic            cs_fall, cs_rise, rd_fall, rd_rise, wr_fall, wr_rise;
    logic [15:0]     addr, addr_inc, off;
    logic [16:0]     win_lim;
    logic            in_win;
    logic [IW-1:0]   idx;
    logic [15:0]     regs_q [NUM_REGS];
    logic            pend, pend_n;
    logic            latch, inc, do_wr, do_fetch;

    // Bus output enable must track the raw pins; the sync path is too slow.
    assign D_OE = RST_N & ~CS & ~RD;
    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_h <= '1;
            rd_h <= '1;
            wr_h <= '1;
        end else begin
            cs_h <= {cs_h[S-2:0], CS};
            rd_h <= {rd_h[S-2:0], RD};
            wr_h <= {wr_h[S-2:0], WR};
        end
    end

    assign cs_fall = (cs_h[S-1:S-2] == 2'b10);
    assign cs_rise = (cs_h[S-1:S-2] == 2'b01);
    assign rd_fall = (rd_h[S-1:S-2] == 2'b10);
    assign rd_rise = (rd_h[S-1:S-2] == 2'b01);
    assign wr_fall = (wr_h[S-1:S-2] == 2'b10);
    assign wr_rise = (wr_h[S-1:S-2] == 2'b01);

    assign addr_inc = addr + 16'd1;
    assign win_lim  = {1'b0, REG_BASE} + 17'(NUM_REGS);
    assign in_win   = ({1'b0, addr} >= {1'b0, REG_BASE}) &&
                      ({1'b0, addr} < win_lim);
    assign off      = addr - REG_BASE;
    assign idx      = off[IW-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end

    // Increments are deferred while a fetch is pending so the fetch
    // always sees the address it was issued against.
    always_comb begin
        state_n  = state;
        pend_n   = pend;
        latch    = 1'b0;
        inc      = 1'b0;
        do_wr    = 1'b0;
        do_fetch = 1'b0;
        if (cs_rise) begin
            state_n = IDLE;
            pend_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        latch   = 1'b1;
                        pend_n  = 1'b0;
                        state_n = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_fall) begin
                        latch  = 1'b1;
                        pend_n = 1'b0;
                    end else if (rd_fall) begin
                        state_n = FETCH;
                        pend_n  = pend | rd_rise | wr_rise;
                    end else begin
                        do_wr  = wr_fall & in_win;
                        inc    = pend | rd_rise | wr_rise;
                        pend_n = 1'b0;
                    end
                end
                FETCH: begin
                    do_fetch = 1'b1;
                    pend_n   = pend | rd_rise | wr_rise;
                    state_n  = ACTIVE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr     <= '0;
            ROM_ADDR <= '0;
            D_OUT    <= '0;
            REG_WSTB <= '0;
            pend     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
        end else begin
            REG_WSTB <= '0;
            pend     <= pend_n;
            if (latch) begin
                addr     <= A_IN;
                ROM_ADDR <= A_IN[ROM_AW-1:0];
            end else if (inc) begin
                addr     <= addr_inc;
                ROM_ADDR <= addr_inc[ROM_AW-1:0];
            end
            if (do_wr) begin
                regs_q[idx]   <= A_IN;
                REG_WSTB[idx] <= 1'b1;
            end
            if (do_fetch) begin
                D_OUT <= in_win ? regs_q[idx] : ROM_DATA;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign REGS[16*g +: 16] = regs_q[g];
    end

endmodule

// File: tb/tb_gba_cart_bus.sv
// Randomised bench for gba_cart_bus against a transaction-level model
// of the cartridge address space.
module tb_gba_cart_bus;

    localparam int S  = 3;
    localparam int NR = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CS = 1'b1;
    logic        RD = 1'b1;
    logic        WR = 1'b1;
    logic [15:0] A_IN = 16'h0;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic [9:0]  ROM_ADDR;
    logic [15:0] ROM_DATA = 16'h0;
    logic [63:0] REGS;
    logic [3:0]  REG_WSTB;
    logic        BUSY;

    gba_cart_bus dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .RD(RD), .WR(WR),
        .A_IN(A_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
        .REGS(REGS), .REG_WSTB(REG_WSTB), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    logic [15:0] rom [1024];
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    logic [15:0] m_regs [NR];
    logic [15:0] m_addr = 16'h0;
    bit          m_busy = 1'b0;
    bit          quiet  = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] flat();
        logic [63:0] r;
        for (int i = 0; i < NR; i++) r[16*i +: 16] = m_regs[i];
        return r;
    endfunction

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'h0400) && (a < 16'h0404);
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (in_win(a)) return m_regs[int'(a - 16'h0400)];
        return rom[a[9:0]];
    endfunction

    always @(negedge CLK) begin
        chk("d_oe", {63'b0, D_OE}, {63'b0, RST_N & ~CS & ~RD});
        if (quiet) begin
            chk("regs", REGS, flat());
            chk("busy", {63'b0, BUSY}, {63'b0, m_busy});
            chk("rom_addr", {54'b0, ROM_ADDR}, {54'b0, m_addr[9:0]});
            chk("wstb_idle", {60'b0, REG_WSTB}, 64'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cs_start(input logic [15:0] a);
        quiet = 1'b0;
        A_IN = a;
        CS = 1'b0;
        tick(S + 3);
        m_addr = a;
        m_busy = 1'b1;
        quiet = 1'b1;
    endtask

    task automatic cs_end();
        quiet = 1'b0;
        CS = 1'b1;
        tick(S + 3);
        m_busy = 1'b0;
        quiet = 1'b1;
    endtask

    task automatic do_read(input string nm);
        logic [15:0] e;
        e = m_read(m_addr);
        quiet = 1'b0;
        RD = 1'b0;
        tick(S + 2);
        chk(nm, {48'b0, D_OUT}, {48'b0, e});
        tick(1);
        RD = 1'b1;
        tick(S + 3);
        m_addr = m_addr + 16'd1;
        quiet = 1'b1;
    endtask

    task automatic do_write(input string nm, input logic [15:0] d);
        logic [3:0] acc, ew;
        int         n;
        bit         w;
        acc = 4'h0;
        n = 0;
        w = in_win(m_addr);
        ew = w ? 4'(1 << int'(m_addr - 16'h0400)) : 4'h0;
        quiet = 1'b0;
        A_IN = d;
        WR = 1'b0;
        repeat (S + 4) begin
            tick(1);
            if (REG_WSTB != 4'h0) begin
                n++;
                acc |= REG_WSTB;
            end
        end
        chk({nm, "_pulses"}, 64'(n), w ? 64'd1 : 64'd0);
        chk({nm, "_wstb"}, {60'b0, acc}, {60'b0, ew});
        if (w) m_regs[int'(m_addr - 16'h0400)] = d;
        WR = 1'b1;
        tick(S + 3);
        m_addr = m_addr + 16'd1;
        quiet = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++)
            rom[i] = (16'($urandom) & 16'hFC00) | 16'(i);
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;

        tick(3);
        RST_N = 1'b1;
        tick(S + 2);
        chk("rst_dout", {48'b0, D_OUT}, 64'h0);
        chk("rst_busy", {63'b0, BUSY}, 64'h0);
        chk("rst_regs", REGS, 64'h0);
        chk("rst_romaddr", {54'b0, ROM_ADDR}, 64'h0);
        quiet = 1'b1;

        cs_start(16'h0002);
        chk("t1_romaddr", {54'b0, ROM_ADDR}, 64'h002);
        quiet = 1'b0;
        RD = 1'b0;
        tick(S);
        chk("t1_early", {48'b0, D_OUT}, 64'h0);
        chk("t1_oe", {63'b0, D_OE}, 64'h1);
        tick(2);
        chk("t1_lat", {48'b0, D_OUT}, {48'b0, rom[2]});
        chk("t1_lit", {54'b0, D_OUT[9:0]}, 64'h002);
        tick(1);
        RD = 1'b1;
        tick(S + 3);
        m_addr = 16'h0003;
        quiet = 1'b1;
        cs_end();

        cs_start(16'h0000);
        for (int k = 0; k < 4; k++) do_read("t2_burst");
        chk("t2_addr", {54'b0, ROM_ADDR}, 64'h004);
        cs_end();

        cs_start(16'h0401);
        do_write("t3_wr", 16'hBEEF);
        chk("t3_reg1", {48'b0, REGS[31:16]}, 64'hBEEF);
        cs_end();
        cs_start(16'h0401);
        do_read("t3_rd");
        cs_end();
        cs_start(16'h0404);
        do_write("t3_out", 16'h1111);
        cs_end();

        cs_start(16'h0400);
        do_write("t5_pre", 16'h5A5A);
        cs_end();
        cs_start(16'h0400);
        quiet = 1'b0;
        A_IN = 16'h1234;
        RD = 1'b0;
        WR = 1'b0;
        tick(S + 2);
        chk("t5_read", {48'b0, D_OUT}, 64'h5A5A);
        tick(1);
        RD = 1'b1;
        WR = 1'b1;
        tick(S + 3);
        m_addr = m_addr + 16'd1;
        quiet = 1'b1;
        do_read("t5_next");
        cs_end();

        cs_start(16'hFFFF);
        do_read("t4_wrap0");
        do_read("t4_wrap1");
        chk("t4_addr", {54'b0, ROM_ADDR}, 64'h001);
        cs_end();

        for (int t = 0; t < 30; t++) begin
            logic [15:0] a;
            if ($urandom_range(0, 2) == 0) a = 16'h03FE + 16'($urandom_range(0, 7));
            else a = 16'($urandom);
            cs_start(a);
            repeat ($urandom_range(2, 5)) begin
                if ($urandom_range(0, 1) == 0) do_read("rnd_rd");
                else do_write("rnd_wr", 16'($urandom));
            end
            cs_end();
        end

        cs_start(16'h0400);
        quiet = 1'b0;
        RD = 1'b0;
        repeat (S) @(posedge CLK);
        #1;
        chk("t6_busy_pre", {63'b0, BUSY}, 64'h1);
        RST_N = 1'b0;
        #1;
        chk("t6_dout", {48'b0, D_OUT}, 64'h0);
        chk("t6_busy", {63'b0, BUSY}, 64'h0);
        chk("t6_regs", REGS, 64'h0);
        chk("t6_oe", {63'b0, D_OE}, 64'h0);
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
        m_addr = 16'h0;
        m_busy = 1'b0;
        CS = 1'b1;
        RD = 1'b1;
        tick(2);
        RST_N = 1'b1;
        tick(S + 3);
        quiet = 1'b1;
        RD = 1'b0;
        tick(S + 3);
        chk("t6_noacc", {48'b0, D_OUT}, 64'h0);
        RD = 1'b1;
        tick(S + 3);

        quiet = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
